// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory arbiter.
// State, owner and block geometry live here so the top and the bench agree.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] OWN_I  = 2'd0;
  localparam logic [1:0] OWN_D  = 2'd1;
  localparam logic [1:0] OWN_WR = 2'd2;

  localparam int          BLOCK_WORDS = 8;
  localparam logic [15:0] BLOCK_MASK  = 16'hFFF0;

  // Byte address of word k inside the block starting at base; wraps at 2^16.
  function automatic logic [15:0] word_addr(input logic [15:0] base, input logic [2:0] k);
    return base + {12'd0, k, 1'b0};
  endfunction

endpackage

// File: rtl/mem_arbiter_fill_counter.sv
// 3-bit word counter used to track issued and returned words of a block fill.
// last flags the enabled step out of word 7, i.e. the final word of the block.
module fill_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [2:0] count,
  output logic       last
);

  always_ff @(posedge clk) begin
    if (rst || clr)
      count <= 3'd0;
    else if (en)
      count <= count + 3'd1;
  end

  assign last = en && (count == 3'd7);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single pipelined memory port between I-fill, D-fill and D stores,
// sequencing 8-word block fills and steering returned words into the owning cache.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_miss_req,
  input  logic [15:0] i_miss_addr,
  input  logic        d_miss_req,
  input  logic [15:0] d_miss_addr,
  input  logic        d_wr_req,
  input  logic [15:0] d_wr_addr,
  input  logic [15:0] d_wr_data,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        fill_we_i,
  output logic        fill_we_d,
  output logic [2:0]  fill_word,
  output logic [15:0] fill_data,
  output logic        i_fill_done,
  output logic        d_fill_done,
  output logic        d_wr_done,
  output logic        busy
);

  state_t      state;
  logic [1:0]  owner;
  logic [15:0] base_addr;
  logic        grant;
  logic        issue_en;
  logic        recv_en;
  logic [2:0]  issue_cnt;
  logic [2:0]  recv_cnt;
  logic        issue_last;
  logic        recv_last;

  assign grant    = (state == IDLE) && (i_miss_req || d_miss_req || d_wr_req);
  assign issue_en = (state == FILL) && mem_en;
  assign recv_en  = (state == FILL) && mem_rvalid;

  fill_counter u_issue (
    .clk   (clk),
    .rst   (rst),
    .clr   (grant),
    .en    (issue_en),
    .count (issue_cnt),
    .last  (issue_last)
  );

  fill_counter u_recv (
    .clk   (clk),
    .rst   (rst),
    .clr   (grant),
    .en    (recv_en),
    .count (recv_cnt),
    .last  (recv_last)
  );

  // Memory-side outputs are registered; the first access is set up at the grant edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= OWN_I;
      base_addr   <= 16'd0;
      mem_en      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= 16'd0;
      mem_wdata   <= 16'd0;
      i_fill_done <= 1'b0;
      d_fill_done <= 1'b0;
      d_wr_done   <= 1'b0;
    end else begin
      i_fill_done <= 1'b0;
      d_fill_done <= 1'b0;
      d_wr_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (d_miss_req) begin
            owner     <= OWN_D;
            base_addr <= d_miss_addr & BLOCK_MASK;
            mem_en    <= 1'b1;
            mem_wr    <= 1'b0;
            mem_addr  <= d_miss_addr & BLOCK_MASK;
            state     <= FILL;
          end else if (d_wr_req) begin
            owner     <= OWN_WR;
            base_addr <= d_wr_addr;
            mem_en    <= 1'b1;
            mem_wr    <= 1'b1;
            mem_addr  <= d_wr_addr;
            mem_wdata <= d_wr_data;
            state     <= WRITE;
          end else if (i_miss_req) begin
            owner     <= OWN_I;
            base_addr <= i_miss_addr & BLOCK_MASK;
            mem_en    <= 1'b1;
            mem_wr    <= 1'b0;
            mem_addr  <= i_miss_addr & BLOCK_MASK;
            state     <= FILL;
          end
        end
        FILL: begin
          if (issue_last) begin
            mem_en   <= 1'b0;
            mem_addr <= 16'd0;
          end else if (mem_en) begin
            mem_addr <= word_addr(base_addr, issue_cnt + 3'd1);
          end
          if (recv_last) begin
            i_fill_done <= (owner == OWN_I);
            d_fill_done <= (owner == OWN_D);
            state       <= DONE;
          end
        end
        WRITE: begin
          mem_en    <= 1'b0;
          mem_wr    <= 1'b0;
          mem_addr  <= 16'd0;
          mem_wdata <= 16'd0;
          d_wr_done <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Returned words are steered straight through; only the fill owner is written.
  assign fill_we_i = recv_en && (owner == OWN_I);
  assign fill_we_d = recv_en && (owner == OWN_D);
  assign fill_word = recv_cnt;
  assign fill_data = mem_rdata;
  assign busy      = (state != IDLE);

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-ported, pipelined main memory between the I-cache miss handler, the D-cache miss handler and D-side write-through stores.
- Sequences each 8-word block fill: issues the addresses, then steers returning words into the requesting cache with a word index.
- Signals completion so the pipeline can release its miss stall.
- Sits between the IF/MEM stage caches and the main memory model.

Parameters:
- BLOCK_WORDS, 8: 16-bit words per cache block. Fixed at 8 for this ISA; fill_word width is log2(BLOCK_WORDS).
- ADDR_W, 16: byte address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_miss_req  in  1  I-cache block fill request; held until i_fill_done.
- i_miss_addr  in  16  I-cache miss byte address.
- d_miss_req  in  1  D-cache block fill request; held until d_fill_done.
- d_miss_addr  in  16  D-cache miss byte address.
- d_wr_req  in  1  write-through store request; held until d_wr_done.
- d_wr_addr  in  16  store byte address.
- d_wr_data  in  16  store data.
- mem_en  out  1  memory access enable.
- mem_wr  out  1  1 = write, 0 = read.
- mem_addr  out  16  memory byte address.
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  memory read data.
- mem_rvalid  in  1  mem_rdata valid; reads return in issue order.
- fill_we_i  out  1  write fill_data into the I-cache block.
- fill_we_d  out  1  write fill_data into the D-cache block.
- fill_word  out  3  word index within the block, 0..7.
- fill_data  out  16  equals mem_rdata.
- i_fill_done  out  1  one-cycle pulse: I fill complete.
- d_fill_done  out  1  one-cycle pulse: D fill complete.
- d_wr_done  out  1  one-cycle pulse: store issued.
- busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, FILL, WRITE, DONE.
- Reset:
  - State goes to IDLE; issue counter, receive counter, owner, latched address and data all clear to 0.
  - Every output is 0.
  - Reset asserted mid-fill or mid-write aborts immediately; no done pulse is produced.
- IDLE, request sampling and priority:
  - Priority is d_miss_req > d_wr_req > i_miss_req.
  - On grant, latch the owner and address. Fill requests latch base = addr & 16'hFFF0; stores latch addr and data.
  - Next state is FILL or WRITE.
  - No memory access in IDLE.
  - mem_rvalid in IDLE is ignored: no fill_we.
- FILL issue:
  - Issue counter k runs 0..7, one read per cycle.
  - Drive mem_en=1, mem_wr=0, mem_addr = base + 2k.
  - Issuing stops after k=7.
- FILL receive:
  - Each cycle with mem_rvalid=1, assert fill_we_i or fill_we_d (owner only).
  - fill_word = receive counter, fill_data = mem_rdata; the receive counter then increments.
  - Issue and receive overlap.
  - After the valid that returns word 7, go to DONE.
- WRITE: one cycle, mem_en=1, mem_wr=1, mem_addr = latched address, mem_wdata = latched data. Then go to DONE.
- DONE:
  - One cycle; pulse the owner's done signal, then return to IDLE.
  - The requester must deassert its req combinationally in the done cycle.
  - A req still high in the following IDLE cycle is treated as a new request.
- Latency:
  - Fill, memory latency L: grant at cycle 0, issues at cycles 1..8, done at cycle 9+L (13 for L=4).
  - Store: grant at 0, write at 1, d_wr_done at 2.
- Request drop mid-operation: the operation completes anyway, including the done pulse; there is no abort.
- Address arithmetic: base + 2k is 16-bit and wraps modulo 2^16. This cannot occur for aligned bases, since k ≤ 7.
- Starvation: I-side may wait while D-side requests persist; this is accepted. The pipeline guarantees D-side requests are finite.
- A request arriving while busy waits; it is sampled only in IDLE.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding localparams IDLE/FILL/WRITE/DONE;
  - owner encoding OWN_I, OWN_D, OWN_WR;
  - BLOCK_WORDS and BLOCK_MASK 16'hFFF0.
- One sub-module: fill_counter, a 3-bit enabled, clearable counter with a terminal flag (count==7 and enable). It is instantiated twice, for issue and for receive.
- State and latches use the team dff cell.

Test Plan:
- I-miss only, i_miss_addr=16'h1234, memory latency 4:
  - mem_addr sequence is 1230, 1232, ..., 123E on cycles 1..8.
  - fill_we_i pulses with fill_word 0..7.
  - i_fill_done at cycle 13.
  - fill_we_d never asserts.
- d_miss_req and i_miss_req both rise in the same cycle, addresses 16'h0040 and 16'h2000:
  - D fill completes first (reads 0040..004E).
  - The I fill starts in the IDLE cycle after d_fill_done.
- d_wr_req with addr 16'h00A6, data 16'hBEEF:
  - Cycle 1: mem_en=1, mem_wr=1, addr 00A6, wdata BEEF.
  - d_wr_done at cycle 2.
- d_wr_req and i_miss_req raised together: the store is served first, and the I fill is granted in the cycle after d_wr_done.
- rst asserted in the 5th FILL cycle:
  - Next cycle all outputs are 0 and the state is IDLE.
  - In-flight mem_rvalid pulses produce no fill_we.
  - No done pulse occurs.
- i_miss_req dropped mid-fill: all 8 fill_we_i pulses still occur, followed by i_fill_done.
- Variable memory latency, 1 and 7 cycles: fill_word remains 0..7 in order, and done arrives at 10 and 16 respectively.
